// File: rtl/seq2_det.sv
// Receive-side checker for the seq2 generator: flags overlapping "10110"
// patterns, locks onto the 5-beat period and flywheel-checks every beat.
module seq2_det #(
  parameter int LOCK_PERIODS = 3,
  parameter int MISS_MAX     = 2,
  parameter int CW           = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  input  logic          din,
  output logic          detect,
  output logic          locked,
  output logic          err,
  output logic [2:0]    phase,
  output logic [CW-1:0] det_count
);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4} det_st_e;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCK}  trk_st_e;

  // Bit ph of this vector is the bit expected at period index ph.
  localparam logic [4:0]    EXP     = 5'b01101;
  localparam logic [3:0]    LP      = 4'(LOCK_PERIODS);
  localparam logic [2:0]    MM      = 3'(MISS_MAX);
  localparam logic [CW-1:0] CNT_MAX = '1;

  det_st_e       det_q, det_d;
  trk_st_e       trk_q, trk_d;
  logic [2:0]    ph_q, ph_d;
  logic [3:0]    good_q, good_d;
  logic [2:0]    miss_q, miss_d;
  logic          detect_q, detect_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       hit;
  logic       mism;
  logic [2:0] ph_inc;

  always_comb begin
    det_d = det_q;
    hit   = 1'b0;
    if (din_valid) begin
      case (det_q)
        S0: det_d = din ? S1 : S0;
        S1: det_d = din ? S1 : S2;
        S2: det_d = din ? S3 : S0;
        S3: det_d = din ? S4 : S2;
        S4: begin
          det_d = din ? S1 : S2;
          hit   = ~din;
        end
        default: det_d = S0;
      endcase
    end
  end

  always_comb begin
    detect_d = hit;
    cnt_d    = cnt_q;
    if (hit && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CW'(1);
  end

  assign mism   = (din != EXP[ph_q]);
  assign ph_inc = (ph_q == 3'd4) ? 3'd0 : ph_q + 3'd1;

  always_comb begin
    trk_d  = trk_q;
    ph_d   = ph_q;
    good_d = good_q;
    miss_d = miss_q;
    err_d  = 1'b0;
    if (din_valid) begin
      case (trk_q)
        HUNT: begin
          if (hit) begin
            ph_d = 3'd0;
            if (LP == 4'd1) begin
              trk_d  = LOCK;
              miss_d = 3'd0;
            end else begin
              trk_d  = VERIFY;
              good_d = 4'd1;
            end
          end
        end
        VERIFY: begin
          if (mism) begin
            // A fresh hit restarts verification instead of dropping to HUNT.
            if (hit) begin
              good_d = 4'd1;
              ph_d   = 3'd0;
            end else begin
              trk_d  = HUNT;
              good_d = 4'd0;
              ph_d   = 3'd0;
            end
          end else begin
            ph_d = ph_inc;
            if (ph_q == 3'd4) begin
              good_d = good_q + 4'd1;
              if (good_q + 4'd1 == LP) begin
                trk_d  = LOCK;
                good_d = 4'd0;
                miss_d = 3'd0;
              end
            end
          end
        end
        LOCK: begin
          ph_d = ph_inc;
          if (mism) begin
            err_d  = 1'b1;
            miss_d = miss_q + 3'd1;
            if (miss_q + 3'd1 == MM) begin
              trk_d  = HUNT;
              miss_d = 3'd0;
              ph_d   = 3'd0;
            end
          end else begin
            miss_d = 3'd0;
          end
        end
        default: begin
          trk_d  = HUNT;
          ph_d   = 3'd0;
          good_d = 4'd0;
          miss_d = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      det_q    <= S0;
      trk_q    <= HUNT;
      ph_q     <= 3'd0;
      good_q   <= 4'd0;
      miss_q   <= 3'd0;
      detect_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      det_q    <= det_d;
      trk_q    <= trk_d;
      ph_q     <= ph_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      detect_q <= detect_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign detect    = detect_q;
  assign err       = err_q;
  assign locked    = (trk_q == LOCK);
  assign phase     = ph_q;
  assign det_count = cnt_q;

endmodule

// File: tb/tb_seq2_det.sv
// Bench for seq2_det: two configurations driven in parallel and checked every
// cycle against a sliding-window / period-index model, plus literal anchors.
module tb_seq2_det;
  logic clk = 1'b0;
  logic rst, din_valid, din;
  logic a_det, a_lock, a_err, b_det, b_lock, b_err;
  logic [2:0] a_ph, b_ph;
  logic [7:0] a_cnt;
  logic [2:0] b_cnt;

  always #5 clk = ~clk;

  seq2_det #(.LOCK_PERIODS(3), .MISS_MAX(2), .CW(8)) dut_a (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .detect(a_det), .locked(a_lock), .err(a_err), .phase(a_ph), .det_count(a_cnt));

  seq2_det #(.LOCK_PERIODS(1), .MISS_MAX(1), .CW(3)) dut_b (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .detect(b_det), .locked(b_lock), .err(b_err), .phase(b_ph), .det_count(b_cnt));

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;
  int pat[5] = '{1, 0, 1, 1, 0};

  // Model configuration and state, index 0 = dut_a, 1 = dut_b.
  int lp[2]   = '{3, 1};
  int mm[2]   = '{2, 1};
  int cmax[2] = '{255, 7};
  int m_hist[2], m_mode[2], m_ph[2], m_good[2], m_miss[2];
  int e_det[2], e_err[2], e_lock[2], e_ph[2], e_cnt[2];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // mode: 0 = hunting, 1 = verifying, 2 = locked
  task automatic mstep(input int k);
    int hit, mis;
    if (rst) begin
      m_hist[k] = 0; m_mode[k] = 0; m_ph[k] = 0; m_good[k] = 0; m_miss[k] = 0;
      e_det[k] = 0; e_err[k] = 0; e_cnt[k] = 0;
    end else if (!din_valid) begin
      e_det[k] = 0; e_err[k] = 0;
    end else begin
      m_hist[k] = ((m_hist[k] << 1) | int'(din)) & 31;
      hit = (m_hist[k] == 'b10110) ? 1 : 0;
      e_det[k] = hit;
      if (hit == 1 && e_cnt[k] < cmax[k]) e_cnt[k]++;
      mis = (int'(din) != pat[m_ph[k]]) ? 1 : 0;
      e_err[k] = 0;
      if (m_mode[k] == 0) begin
        if (hit == 1) begin
          m_ph[k] = 0;
          if (lp[k] == 1) begin m_mode[k] = 2; m_miss[k] = 0; end
          else begin m_mode[k] = 1; m_good[k] = 1; end
        end
      end else if (m_mode[k] == 1) begin
        if (mis == 1) begin
          m_ph[k] = 0;
          if (hit == 1) m_good[k] = 1;
          else begin m_mode[k] = 0; m_good[k] = 0; end
        end else begin
          if (m_ph[k] == 4) begin
            m_good[k]++;
            if (m_good[k] == lp[k]) begin m_mode[k] = 2; m_miss[k] = 0; end
          end
          m_ph[k] = (m_ph[k] + 1) % 5;
        end
      end else begin
        m_ph[k] = (m_ph[k] + 1) % 5;
        e_err[k] = mis;
        if (mis == 1) begin
          m_miss[k]++;
          if (m_miss[k] == mm[k]) begin m_mode[k] = 0; m_miss[k] = 0; m_ph[k] = 0; end
        end else m_miss[k] = 0;
      end
    end
    e_lock[k] = (m_mode[k] == 2) ? 1 : 0;
    e_ph[k] = m_ph[k];
  endtask

  always @(posedge clk) begin
    mstep(0);
    mstep(1);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("A.detect", int'(a_det), e_det[0]);
      chk("A.err", int'(a_err), e_err[0]);
      chk("A.locked", int'(a_lock), e_lock[0]);
      chk("A.phase", int'(a_ph), e_ph[0]);
      chk("A.det_count", int'(a_cnt), e_cnt[0]);
      chk("B.detect", int'(b_det), e_det[1]);
      chk("B.err", int'(b_err), e_err[1]);
      chk("B.locked", int'(b_lock), e_lock[1]);
      chk("B.phase", int'(b_ph), e_ph[1]);
      chk("B.det_count", int'(b_cnt), e_cnt[1]);
    end
  end

  function automatic bit gen(input int i);
    return (i == 0) ? 1'b1 : bit'(pat[(i - 1) % 5]);
  endfunction

  task automatic step(input bit r, input bit v, input bit d);
    rst = r; din_valid = v; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bit b;
    int seq5[8] = '{1, 0, 1, 1, 0, 1, 1, 0};
    rst = 1'b1; din_valid = 1'b0; din = 1'b0;
    do_reset();
    cmp_en = 1'b1;
    chk("reset.detect", int'(a_det), 0);
    chk("reset.locked", int'(a_lock), 0);
    chk("reset.det_count", int'(a_cnt), 0);

    // Generator stream, valid every cycle, then error / loss-of-lock / relock.
    for (int i = 0; i < 51; i++) begin
      b = gen(i);
      if (i == 23 || i == 26 || i == 27) b = ~b;
      step(1'b0, 1'b1, b);
      if (i == 5)  chk("p1.detect_b6", int'(a_det), 1);
      if (i == 5)  chk("p1.B_locked_b6", int'(b_lock), 1);
      if (i == 14) chk("p1.locked_b15", int'(a_lock), 0);
      if (i == 15) chk("p1.locked_b16", int'(a_lock), 1);
      if (i == 20) chk("p1.det_count", int'(a_cnt), 4);
      if (i == 23) chk("p3.err", int'(a_err), 1);
      if (i == 23) chk("p3.still_locked", int'(a_lock), 1);
      if (i == 24) chk("p3.err_clear", int'(a_err), 0);
      if (i == 26) chk("p4.err1_locked", int'(a_lock), 1);
      if (i == 27) chk("p4.err2", int'(a_err), 1);
      if (i == 27) chk("p4.lost", int'(a_lock), 0);
      if (i == 44) chk("p4.not_yet", int'(a_lock), 0);
      if (i == 45) chk("p4.relock", int'(a_lock), 1);
    end

    // Same stream with alternating valid.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      step(1'b0, 1'b1, gen(i));
      if (i == 5)  chk("p2.detect_b6", int'(a_det), 1);
      if (i == 15) chk("p2.locked_b16", int'(a_lock), 1);
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      if (i == 5)  chk("p2.idle_detect", int'(a_det), 0);
    end
    chk("p2.det_count", int'(a_cnt), 4);

    // Overlapping occurrences from HUNT.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'(seq5[i]));
      if (i == 4) chk("p5.detect_b5", int'(a_det), 1);
    end
    chk("p5.detect_b8", int'(a_det), 1);
    chk("p5.phase_b8", int'(a_ph), 0);
    chk("p5.locked_b8", int'(a_lock), 0);
    chk("p5.det_count", int'(a_cnt), 2);

    // Saturation on the narrow counter, then reset while locked.
    do_reset();
    for (int i = 0; i < 48; i++) step(1'b0, 1'b1, gen(i));
    chk("p6.B_sat", int'(b_cnt), 7);
    chk("p6.A_cnt9", int'(a_cnt), 9);
    chk("p6.pre_rst_locked", int'(a_lock), 1);
    step(1'b1, 1'b1, 1'b1);
    chk("p6.rst_locked", int'(a_lock), 0);
    chk("p6.rst_phase", int'(a_ph), 0);
    chk("p6.rst_cnt", int'(a_cnt), 0);
    chk("p6.rst_detect", int'(a_det), 0);
    chk("p6.rst_err", int'(a_err), 0);

    // Randomized bursts: generator stream with sparse corruption or pure noise.
    for (int burst = 0; burst < 40; burst++) begin
      int noisy = $urandom_range(0, 3) == 0;
      int base = $urandom_range(0, 4);
      int n = 0;
      for (int c = 0; c < 60; c++) begin
        bit r = ($urandom_range(0, 199) == 0);
        bit v = ($urandom_range(0, 4) != 0);
        if (noisy) b = 1'($urandom_range(0, 1));
        else begin
          b = bit'(pat[(base + n) % 5]);
          if ($urandom_range(0, 29) == 0) b = ~b;
        end
        if (v) n++;
        step(r, v, b);
      end
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
